// File: rtl/reset_sequencer.sv
// PLL-driven reset sequencer: waits for lock, holds the core in reset, then
// releases core and video resets in turn. Lock losses restart it and are counted.
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 1024,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       ext_reset_req,
    output logic       core_reset,
    output logic       video_reset,
    output logic       ready,
    output logic [7:0] lock_loss_count
);
    // state     | meaning
    // WAIT_LOCK | no synchronised lock; both resets asserted
    // HOLD      | locked, counting HOLD_CYCLES before core release
    // CORE      | core released, counting STAGGER_CYCLES before video release
    // RUN       | all resets released, ready high

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, CORE, RUN} state_t;

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   lock_s;
    logic                   ext_s;
    state_t                 state;
    logic [CNT_W-1:0]       counter;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_sync <= '0;
            ext_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
            ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_reset_req};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign ext_s  = ext_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= WAIT_LOCK;
            counter         <= '0;
            core_reset      <= 1'b1;
            video_reset     <= 1'b1;
            ready           <= 1'b0;
            lock_loss_count <= '0;
        end else if (state != WAIT_LOCK && !lock_s) begin
            // Lock loss outranks an external request arriving on the same edge.
            state       <= WAIT_LOCK;
            counter     <= '0;
            core_reset  <= 1'b1;
            video_reset <= 1'b1;
            ready       <= 1'b0;
            if (lock_loss_count != 8'hFF) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state   <= HOLD;
                        counter <= '0;
                    end
                end
                HOLD: begin
                    if (ext_s) begin
                        counter <= '0;
                    end else if (counter == HOLD_LAST) begin
                        state      <= CORE;
                        counter    <= '0;
                        core_reset <= 1'b0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                CORE, RUN: begin
                    if (ext_s) begin
                        state       <= HOLD;
                        counter     <= '0;
                        core_reset  <= 1'b1;
                        video_reset <= 1'b1;
                        ready       <= 1'b0;
                    end else if (state == CORE) begin
                        if (counter == STAGGER_LAST) begin
                            state       <= RUN;
                            video_reset <= 1'b0;
                            ready       <= 1'b1;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= WAIT_LOCK;
                    counter     <= '0;
                    core_reset  <= 1'b1;
                    video_reset <= 1'b1;
                    ready       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, hand-written corner cases
// and random bursts compared against an elapsed-time reference model.
module tb_reset_sequencer;
    localparam int SYNC    = 2;
    localparam int HOLD    = 8;
    localparam int STAGGER = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked;
    logic       ext_reset_req;
    logic       core_reset;
    logic       video_reset;
    logic       ready;
    logic [7:0] lock_loss_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .HOLD_CYCLES   (HOLD),
        .STAGGER_CYCLES(STAGGER)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .locked         (locked),
        .ext_reset_req  (ext_reset_req),
        .core_reset     (core_reset),
        .video_reset    (video_reset),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    // Reference model: input samples reach the sequencer SYNC edges later;
    // the sequence is tracked as edges elapsed since the last (re)start.
    bit q_lock[$];
    bit q_ext[$];
    bit m_wait;
    int m_since;
    int m_loss;

    function automatic void model_reset();
        q_lock = {};
        q_ext  = {};
        for (int i = 0; i < SYNC; i++) begin
            q_lock.push_back(1'b0);
            q_ext.push_back(1'b0);
        end
        m_wait  = 1'b1;
        m_since = 0;
        m_loss  = 0;
    endfunction

    function automatic void model_edge(bit l, bit e);
        bit ls;
        bit es;
        ls = q_lock.pop_front();
        es = q_ext.pop_front();
        q_lock.push_back(l);
        q_ext.push_back(e);
        if (m_wait) begin
            if (ls) begin
                m_wait  = 1'b0;
                m_since = 0;
            end
        end else if (!ls) begin
            m_wait = 1'b1;
            if (m_loss < 255) m_loss++;
        end else if (es) begin
            m_since = 0;
        end else if (m_since < HOLD + STAGGER) begin
            m_since++;
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit exp_ready;
        exp_ready = !m_wait && (m_since >= HOLD + STAGGER);
        check("model core_reset", core_reset, m_wait || (m_since < HOLD));
        check("model video_reset", video_reset, !exp_ready);
        check("model ready", ready, exp_ready);
        check("model lock_loss_count", lock_loss_count, m_loss);
    endtask

    task automatic check_outs(string tag, bit c, bit v, bit r, int cnt);
        check({tag, " core_reset"}, core_reset, c);
        check({tag, " video_reset"}, video_reset, v);
        check({tag, " ready"}, ready, r);
        check({tag, " lock_loss_count"}, lock_loss_count, cnt);
    endtask

    // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
    task automatic cycle(bit l, bit e);
        locked        = l;
        ext_reset_req = e;
        @(posedge clock);
        model_edge(l, e);
        @(negedge clock);
        check_model();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        int n;
        bit l;
        bit e;
        bit core;
        bit video;
        bit rdy;
        int cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        locked        = 1'b0;
        ext_reset_req = 1'b0;
        reset         = 1'b1;
        model_reset();

        // power-up: core falls at E10, video/ready at E14
        vecs.push_back('{10, 1, 0, 1, 1, 0, 0});
        vecs.push_back('{ 1, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{ 3, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{ 1, 1, 0, 0, 0, 1, 0});
        // lock loss in RUN, then re-lock
        vecs.push_back('{ 2, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{ 1, 0, 0, 1, 1, 0, 1});
        vecs.push_back('{10, 1, 0, 1, 1, 0, 1});
        vecs.push_back('{ 1, 1, 0, 0, 1, 0, 1});
        vecs.push_back('{ 3, 1, 0, 0, 1, 0, 1});
        vecs.push_back('{ 1, 1, 0, 0, 0, 1, 1});
        // 5-cycle external request in RUN
        vecs.push_back('{ 2, 1, 1, 0, 0, 1, 1});
        vecs.push_back('{ 1, 1, 1, 1, 1, 0, 1});
        vecs.push_back('{ 2, 1, 1, 1, 1, 0, 1});
        vecs.push_back('{ 9, 1, 0, 1, 1, 0, 1});
        vecs.push_back('{ 1, 1, 0, 0, 1, 0, 1});
        vecs.push_back('{ 3, 1, 0, 0, 1, 0, 1});
        vecs.push_back('{ 1, 1, 0, 0, 0, 1, 1});
        // lock loss and external request on the same edge
        vecs.push_back('{ 2, 0, 1, 0, 0, 1, 1});
        vecs.push_back('{ 1, 0, 1, 1, 1, 0, 2});
        vecs.push_back('{ 3, 0, 0, 1, 1, 0, 2});
        vecs.push_back('{ 3, 0, 1, 1, 1, 0, 2});
        vecs.push_back('{10, 1, 0, 1, 1, 0, 2});
        vecs.push_back('{ 1, 1, 0, 0, 1, 0, 2});
        vecs.push_back('{ 4, 1, 0, 0, 0, 1, 2});

        repeat (3) @(negedge clock);
        check_outs("in reset", 1, 1, 0, 0);
        reset = 1'b0;
        @(negedge clock);
        check_outs("after reset", 1, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].n) cycle(vecs[i].l, vecs[i].e);
            check_outs($sformatf("vec %0d", i), vecs[i].core, vecs[i].video, vecs[i].rdy, vecs[i].cnt);
        end

        // lock toggling: counter must saturate, never wrap
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
        repeat (4) cycle(1'b0, 1'b0);
        check("saturated lock_loss_count", lock_loss_count, 255);

        // async reset while in CORE
        apply_reset();
        repeat (11) cycle(1'b1, 1'b0);
        check_outs("in CORE", 0, 1, 0, 0);
        #2 reset = 1'b1;
        #1 check_outs("async reset", 1, 1, 0, 0);
        model_reset();
        locked = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) cycle(1'b1, 1'b0);
        check_outs("restart E9", 1, 1, 0, 0);
        repeat (1) cycle(1'b1, 1'b0);
        check_outs("restart E10", 0, 1, 0, 0);
        repeat (3) cycle(1'b1, 1'b0);
        check_outs("restart E13", 0, 1, 0, 0);
        repeat (1) cycle(1'b1, 1'b0);
        check_outs("restart E14", 0, 0, 1, 0);

        // random bursts of lock/ext levels
        for (int s = 0; s < 200; s++) begin
            int len;
            bit l;
            bit e;
            len = $urandom_range(1, 20);
            l   = ($urandom_range(0, 3) != 0);
            e   = ($urandom_range(0, 5) == 0);
            repeat (len) cycle(l, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in each input synchroniser (legal values 2..4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024, meaning the number of clocks after synchronised lock before core reset release (legal values >= 2).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 16, meaning the number of clocks between core and video reset release (legal values >= 2).
REQ-004 SHALL have port clock, input, 1 bit: the PLL output clock; all logic is on this single clock.
REQ-005 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 SHALL have port locked, input, 1 bit: the PLL lock indication, asynchronous to clock.
REQ-007 SHALL have port ext_reset_req, input, 1 bit: button or host reset request, asynchronous, level-sensitive.
REQ-008 SHALL have port core_reset, output, 1 bit: active-high reset for the emulation core.
REQ-009 SHALL have port video_reset, output, 1 bit: active-high reset for the video/HDMI path.
REQ-010 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-011 SHALL have port lock_loss_count, output, 8 bits: count of lock-loss events, saturating.

Function
REQ-012 SHALL pass locked and ext_reset_req each through an independent SYNC_STAGES-flop synchroniser, producing lock_s and ext_s.
REQ-013 SHALL implement states WAIT_LOCK, HOLD, CORE and RUN, with one shared counter whose width is sized for max(HOLD_CYCLES, STAGGER_CYCLES).
REQ-014 SHALL, in WAIT_LOCK, move to HOLD with counter=0 on the first edge at which lock_s=1; otherwise it SHALL remain in WAIT_LOCK.
REQ-015 SHALL, in HOLD, move to CORE with counter=0 when counter==HOLD_CYCLES-1; otherwise it SHALL increment the counter.
REQ-016 SHALL, in CORE, move to RUN when counter==STAGGER_CYCLES-1; otherwise it SHALL increment the counter.
REQ-017 SHALL register all outputs so they change on the same edge as the state change:
- core_reset=1 in WAIT_LOCK and HOLD;
- video_reset=1 in every state except RUN;
- ready=1 only in RUN.
REQ-018 SHALL, in HOLD, CORE or RUN, move to WAIT_LOCK on the next edge whenever lock_s=0, and SHALL reassert both resets and drop ready on that same edge.
REQ-019 SHALL increment lock_loss_count by 1 on each REQ-018 transition, saturating at 255 with no wrap.
REQ-020 SHALL, in CORE or RUN with ext_s=1 and lock_s=1, move to HOLD with counter=0; while ext_s=1 in HOLD, the counter SHALL stay at 0.
REQ-021 SHALL NOT change lock_loss_count on an ext_s-caused transition.
REQ-022 SHALL give lock loss priority over ext_s when both occur on the same edge, with a single increment of lock_loss_count.
REQ-023 SHALL ignore ext_s in WAIT_LOCK.
REQ-024 SHALL NOT glitch core_reset or video_reset: both SHALL be direct flop outputs.

Reset
REQ-025 SHALL, on reset=1 and asynchronously, set state=WAIT_LOCK, counter=0, all synchroniser flops=0, core_reset=1, video_reset=1, ready=0 and lock_loss_count=0.
REQ-026 SHALL keep every output at its reset value after reset deasserts until the sequence of REQ-014..REQ-016 completes; reset asserted mid-sequence SHALL return immediately to the REQ-025 values.

Verification (SYNC_STAGES=2, HOLD_CYCLES=8, STAGGER_CYCLES=4; E0 is the first edge sampling locked=1)
REQ-027 Power-up: hold locked=1 from E0.
-> lock_s=1 after E1; HOLD after E2.
-> core_reset falls at E10.
-> video_reset falls and ready rises at E14.
REQ-028 Lock loss in RUN: drop locked for 3 cycles.
-> both resets high and ready=0 two edges after sampling, plus one edge.
-> lock_loss_count=1; re-lock repeats the 12-edge release sequence.
REQ-029 ext_reset_req pulsed for 5 cycles in RUN.
-> HOLD; the counter is held at 0 while ext_s=1.
-> core_reset falls 8 edges after ext_s falls; lock_loss_count is unchanged.
REQ-030 Simultaneous lock_s fall and ext_s rise in RUN.
-> WAIT_LOCK; lock_loss_count increments exactly once.
REQ-031 Toggle lock 300 times.
-> lock_loss_count saturates at 255.
REQ-032 Assert reset while in CORE.
-> all outputs immediately take the REQ-025 values, without waiting for a clock edge; after reset deasserts, the full sequence restarts from WAIT_LOCK.
